// File: rtl/npu8_q_pkg.sv
// rtl/npu8_q_pkg.sv - shared pack-state encoding, lane masks and word type for the quantized output path
package npu8_q_pkg;

  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL1 = 2'd1;
  localparam logic [1:0] ST_FILL2 = 2'd2;
  localparam logic [1:0] ST_FILL3 = 2'd3;

  localparam logic [3:0] MASK_1 = 4'h1;
  localparam logic [3:0] MASK_2 = 4'h3;
  localparam logic [3:0] MASK_3 = 4'h7;
  localparam logic [3:0] MASK_4 = 4'hF;

  typedef struct packed {
    logic [3:0]  byte_en;
    logic [31:0] data;
  } pack_word_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return MASK_1;
      3'd2:    return MASK_2;
      3'd3:    return MASK_3;
      3'd4:    return MASK_4;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo32.sv
// rtl/sync_fifo32.sv - single-clock FIFO with valid/ready ports; accepts a write when full if a read happens in the same cycle
module sync_fifo32 #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_tvalid,
  output logic             wr_tready,
  input  logic [WIDTH-1:0] wr_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic [WIDTH-1:0] rd_tdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_tvalid = !empty;
  assign do_rd     = rd_tvalid && rd_tready;
  assign wr_tready = !full || do_rd;
  assign do_wr     = wr_tvalid && wr_tready;
  assign rd_tdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_tdata;
  end

endmodule

// File: rtl/q_out_pack8.sv
// rtl/q_out_pack8.sv - packs clamped quantized bytes into 32-bit words; Q_OUT_PACK8_STAT_EN adds MIN/MAX outputs
module q_out_pack8
  import npu8_q_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INPUT_EN,
  input  logic [7:0]       D_IN,
  input  logic             RELU_EN,
  input  logic [7:0]       ZERO_POINT,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_DATA,
  output logic [3:0]       OUT_BYTE_EN,
  output logic             OVERFLOW,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic             BUSY
`ifdef Q_OUT_PACK8_STAT_EN
  ,
  output logic [7:0]       MIN,
  output logic [7:0]       MAX
`endif
);

  logic [7:0]  b;
  logic [1:0]  state;
  logic [23:0] lanes;
  logic [2:0]  fill_next;
  logic        push;
  logic        push_ready;
  pack_word_t  push_word;
  pack_word_t  head_word;

  assign b = (RELU_EN && (D_IN < ZERO_POINT)) ? ZERO_POINT : D_IN;

  // Bytes held once this cycle's strobe lands; a flush pushes whatever that is.
  assign fill_next = {1'b0, state} + {2'b00, INPUT_EN};
  assign push      = (INPUT_EN && (state == ST_FILL3)) || (FLUSH && (fill_next != 3'd0));

  always_comb begin
    push_word.data = {8'h00, lanes};
    if (INPUT_EN) push_word.data[{state, 3'b000} +: 8] = b;
    push_word.byte_en = lane_mask(fill_next);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_EMPTY;
      lanes <= '0;
    end else if (push) begin
      state <= ST_EMPTY;
      lanes <= '0;
    end else if (INPUT_EN) begin
      state <= state + 2'd1;
      lanes <= push_word.data[23:0];
    end
  end

  sync_fifo32 #(
    .WIDTH (36),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .reset     (RESET),
    .wr_tvalid (push),
    .wr_tready (push_ready),
    .wr_tdata  (push_word),
    .rd_tvalid (OUT_VALID),
    .rd_tready (OUT_READY),
    .rd_tdata  (head_word)
  );

  assign OUT_DATA    = head_word.data;
  assign OUT_BYTE_EN = head_word.byte_en;
  assign BUSY        = (state != ST_EMPTY) || OUT_VALID;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      WORD_CNT <= '0;
      OVERFLOW <= 1'b0;
    end else if (push && push_ready) begin
      WORD_CNT <= WORD_CNT + CNT_W'(1);
    end else if (push) begin
      OVERFLOW <= 1'b1;
    end
  end

`ifdef Q_OUT_PACK8_STAT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MIN <= 8'hFF;
      MAX <= 8'h00;
    end else if (INPUT_EN) begin
      if (b < MIN) MIN <= b;
      if (b > MAX) MAX <= b;
    end
  end
`endif

endmodule

// File: doc/q_out_pack8.md
Q_OUT_PACK8 -- requirements
Module: q_out_pack8

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of 32-bit words buffered (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of WORD_CNT.
REQ-003 SHALL have port CLK  input  1  single clock for all state.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port INPUT_EN  input  1  byte strobe from the upstream quantized-add stage (no backpressure).
REQ-006 SHALL have port D_IN  input  8  unsigned quantized result byte.
REQ-007 SHALL have port RELU_EN  input  1  enables zero-point clamp.
REQ-008 SHALL have port ZERO_POINT  input  8  quantized zero value for the clamp.
REQ-009 SHALL have port FLUSH  input  1  single-cycle pulse that emits a partial word.
REQ-010 SHALL have port OUT_VALID  output  1  FIFO head valid.
REQ-011 SHALL have port OUT_READY  input  1  consumer accepts head.
REQ-012 SHALL have port OUT_DATA  output  32  packed word; the first byte goes in [7:0].
REQ-013 SHALL have port OUT_BYTE_EN  output  4  valid-lane mask of OUT_DATA.
REQ-014 SHALL have port OVERFLOW  output  1  sticky word-dropped flag.
REQ-015 SHALL have port WORD_CNT  output  CNT_W  count of words accepted into the FIFO.
REQ-016 SHALL have port BUSY  output  1  high when the pack register or FIFO is non-empty.

Function
REQ-017 SHALL compute byte b = (RELU_EN && D_IN < ZERO_POINT, unsigned) ? ZERO_POINT : D_IN.
REQ-018 SHALL implement pack FSM states EMPTY, FILL1, FILL2, FILL3 and advance one state per INPUT_EN, with b written to lane index = state.
REQ-019 SHALL, on INPUT_EN in FILL3, push {b, lanes2..0} with OUT_BYTE_EN=4'hF and return to EMPTY in the same cycle.
REQ-020 SHALL, on FLUSH in FILL1..FILL3, push the partial word with unused lanes zero and OUT_BYTE_EN = 4'h1/4'h3/4'h7, then go to EMPTY.
REQ-021 SHALL treat FLUSH in EMPTY as a no-op.
REQ-022 SHALL, on FLUSH with INPUT_EN in the same cycle, include the new byte first and then push (a full word from FILL3 gives mask 4'hF).
REQ-023 SHALL give a pushed word a latency of one cycle from its push-cycle edge to appearing on OUT_VALID.
REQ-024 SHALL pop the FIFO on OUT_VALID && OUT_READY.
REQ-025 SHALL hold OUT_DATA and OUT_BYTE_EN stable while OUT_VALID && !OUT_READY.
REQ-026 SHALL drop a push into a full FIFO, set OVERFLOW, and leave WORD_CNT unchanged.
REQ-027 SHALL accept a push into a full FIFO if a pop occurs in the same cycle.
REQ-028 SHALL increment WORD_CNT per accepted push, wrapping from all-ones to 0.
REQ-029 SHALL keep OVERFLOW set until RESET.

Reset
REQ-030 SHALL, on RESET high at a CLK edge, set FSM=EMPTY, lanes=0, FIFO empty, OUT_VALID=0, OUT_DATA=0, OUT_BYTE_EN=0, OVERFLOW=0, WORD_CNT=0, BUSY=0, MIN=8'hFF, MAX=8'h00.
REQ-031 SHALL discard a partially packed word and FIFO contents on reset mid-operation, emitting no flush.
REQ-032 SHALL give RESET priority over INPUT_EN, FLUSH and OUT_READY in the same cycle.

Configuration
REQ-033 SHALL, with macro Q_OUT_PACK8_STAT_EN defined, add outputs MIN[7:0] and MAX[7:0], updated on each INPUT_EN with post-clamp b (MIN<=b if b<MIN, MAX<=b if b>MAX), reset per REQ-030.
REQ-034 SHALL, without Q_OUT_PACK8_STAT_EN, omit MIN/MAX ports and logic; all other behaviour is identical.

Structure
REQ-035 SHALL take pack state encoding, lane-mask constants (4'h1, 4'h3, 4'h7, 4'hF) and the default FIFO_DEPTH from shared package npu8_q_pkg.
REQ-036 SHALL implement the buffer as sub-module sync_fifo32 (width 36 = data plus mask, depth FIFO_DEPTH, synchronous active-high reset).

Verification
REQ-037 SHALL cover: bytes 01,02,03,04 with RELU_EN=0 -> one word 32'h04030201, mask F, next cycle after push, WORD_CNT=1.
REQ-038 SHALL cover: RELU_EN=1, ZERO_POINT=8'h80, bytes 10,90,80,7F -> word 32'h80809080.
REQ-039 SHALL cover: bytes AA,BB then FLUSH -> word 32'h0000BBAA, mask 3; FLUSH with INPUT_EN in FILL3 -> mask F.
REQ-040 SHALL cover: OUT_READY=0, push FIFO_DEPTH+1 words -> OVERFLOW=1, WORD_CNT=FIFO_DEPTH, head word stable; then push on full with pop -> accepted.
REQ-041 SHALL cover: RESET asserted in FILL2 with a FIFO word pending -> OUT_VALID=0 next cycle, BUSY=0, no partial word emitted.
REQ-042 SHALL cover: STAT_EN build, bytes 05,F0,00 -> MIN=00, MAX=F0; non-STAT build compiles without MIN/MAX.
